// File: rtl/sia_receiver.sv
// Asynchronous serial receiver: synchronizes rxd/rxc, recovers mid-bit sample points from
// rxd/rxc edges and shifts received bits into the MSB of a right-shifting register.
module sia_receiver #(
   parameter int unsigned SHIFT_REG_WIDTH = 64,
   parameter int unsigned BAUD_RATE_WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [5:0]                 bits_i,
   input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
   input  logic                       eedd_i,
   input  logic                       eedc_i,
   input  logic                       rxd_i,
   input  logic                       rxc_i,
   output logic [SHIFT_REG_WIDTH-1:0] dat_o,
   output logic                       idle_o,
   output logic                       sample_to
);

   localparam logic [BAUD_RATE_WIDTH-1:0] BaudOne = BAUD_RATE_WIDTH'(1);

   logic                       r_rxd_meta, r_rxd_sync, r_rxd_prev;
   logic                       r_rxc_meta, r_rxc_sync, r_rxc_prev;
   logic [BAUD_RATE_WIDTH-1:0] r_baud;
   logic [5:0]                 r_bits;
   logic [SHIFT_REG_WIDTH-1:0] r_dat;
   logic                       r_sample;

   logic                       w_idle;
   logic                       w_start;
   logic                       w_edge;
   logic                       w_sample;
   logic [BAUD_RATE_WIDTH-1:0] w_baud_d;
   logic [5:0]                 w_bits_d;
   logic [SHIFT_REG_WIDTH-1:0] w_dat_d;

   always_comb begin
      w_idle   = (r_bits == 6'd0);
      w_start  = w_idle & r_rxd_prev & ~r_rxd_sync;
      w_edge   = (eedd_i & (r_rxd_prev ^ r_rxd_sync)) |
                 (eedc_i & r_rxc_sync & ~r_rxc_prev);
      // Any resync (including the frame start) wins over the sample/reload of this clock.
      w_sample = ~w_edge & ~w_start & (r_baud == '0);

      w_baud_d = r_baud - BaudOne;
      if (w_edge || w_start) begin
         w_baud_d = baud_i >> 1;
      end else if (w_sample) begin
         w_baud_d = baud_i;
      end

      w_bits_d = r_bits;
      w_dat_d  = r_dat;
      if (w_start) begin
         w_bits_d = bits_i;
      end else if (w_sample && !w_idle) begin
         w_bits_d = r_bits - 6'd1;
         w_dat_d  = {r_rxd_sync, r_dat[SHIFT_REG_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_rxd_meta <= 1'b1;
         r_rxd_sync <= 1'b1;
         r_rxd_prev <= 1'b1;
         r_rxc_meta <= 1'b0;
         r_rxc_sync <= 1'b0;
         r_rxc_prev <= 1'b0;
         r_baud     <= '0;
         r_bits     <= 6'd0;
         r_dat      <= '1;
         r_sample   <= 1'b0;
      end else begin
         r_rxd_meta <= rxd_i;
         r_rxd_sync <= r_rxd_meta;
         r_rxd_prev <= r_rxd_sync;
         r_rxc_meta <= rxc_i;
         r_rxc_sync <= r_rxc_meta;
         r_rxc_prev <= r_rxc_sync;
         r_baud     <= w_baud_d;
         r_bits     <= w_bits_d;
         r_dat      <= w_dat_d;
         r_sample   <= w_sample;
      end
   end

   assign dat_o     = r_dat;
   assign idle_o    = w_idle;
   assign sample_to = r_sample;

endmodule

// File: tb/tb_sia_receiver.sv
// Directed bench for sia_receiver: rxd-edge framing, rxc-clocked framing, reset abort,
// fixed sample spacing without resync, and bits_i/baud_i corner cases.
module tb_sia_receiver;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [5:0]  bits_i;
   logic [31:0] baud_i;
   logic        eedd_i, eedc_i, rxd_i, rxc_i;
   logic [63:0] dat_o;
   logic        idle_o, sample_to;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_cnt = 0;

   sia_receiver #(.SHIFT_REG_WIDTH(64), .BAUD_RATE_WIDTH(32)) u_dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .bits_i    (bits_i),
      .baud_i    (baud_i),
      .eedd_i    (eedd_i),
      .eedc_i    (eedc_i),
      .rxd_i     (rxd_i),
      .rxc_i     (rxc_i),
      .dat_o     (dat_o),
      .idle_o    (idle_o),
      .sample_to (sample_to)
   );

   always #10 clk_i = ~clk_i;
   always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      rxd_i   = 1'b1;
      rxc_i   = 1'b0;
      repeat (3) @(negedge clk_i);
      reset_i = 1'b1;
      repeat (3) @(negedge clk_i);
   endtask

   // Drive n bits (LSB first), one bit per 50 clocks; check after each bit period.
   task automatic send_bits(input string tag, input logic [10:0] pat, input int n,
                            input int frame_len, inout logic [63:0] exp_dat);
      for (int k = 0; k < n; k++) begin
         rxd_i = pat[k];
         repeat (50) @(negedge clk_i);
         exp_dat = {pat[k], exp_dat[63:1]};
         check_eq($sformatf("%s_dat%0d", tag, k), dat_o, exp_dat);
         check_eq($sformatf("%s_idle%0d", tag, k), 64'(idle_o), 64'(k + 1 >= frame_len));
      end
   endtask

   task automatic wait_sample(input string tag, output int cyc);
      int t = 0;
      cyc = -1;
      @(negedge clk_i);
      while (sample_to !== 1'b1 && t < 200) begin
         @(negedge clk_i);
         t++;
      end
      if (sample_to === 1'b1) cyc = cyc_cnt;
      else check_eq({tag, "_timeout"}, 64'(sample_to), 64'd1);
   endtask

   initial begin
      logic [63:0] exp_dat;
      int s0, s1, s2;
      bits_i  = 6'd11;
      baud_i  = 32'd49;
      eedd_i  = 1'b1;
      eedc_i  = 1'b1;
      reset_i = 1'b0;
      rxd_i   = 1'b1;
      rxc_i   = 1'b0;
      repeat (2) @(negedge clk_i);
      check_eq("rst_dat", dat_o, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("rst_idle", 64'(idle_o), 64'd1);
      check_eq("rst_sample", 64'(sample_to), 64'd0);
      do_reset();

      // 8O1-style frame via rxd edges, then an extra idle-high bit period
      exp_dat = '1;
      send_bits("rxd", 11'b101_0000_1010, 11, 11, exp_dat);
      rxd_i = 1'b1;
      repeat (50) @(negedge clk_i);
      check_eq("post_dat", dat_o, exp_dat);
      check_eq("post_idle", 64'(idle_o), 64'd1);

      // rxd held low, bits clocked by rxc rising edges
      do_reset();
      exp_dat = '1;
      for (int n = 1; n <= 11; n++) begin
         rxc_i = 1'b1;
         if (n == 1) rxd_i = 1'b0;
         repeat (25) @(negedge clk_i);
         rxc_i = 1'b0;
         repeat (25) @(negedge clk_i);
         exp_dat = {1'b0, exp_dat[63:1]};
         check_eq($sformatf("rxc_dat%0d", n), dat_o, exp_dat);
         check_eq($sformatf("rxc_idle%0d", n), 64'(idle_o), 64'(n == 11));
      end

      // Reset mid-frame aborts asynchronously; next falling edge starts a fresh frame
      do_reset();
      exp_dat = '1;
      send_bits("pre", 11'b110, 3, 11, exp_dat);
      @(negedge clk_i);
      #5 reset_i = 1'b0;
      #1;
      check_eq("abort_dat", dat_o, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("abort_idle", 64'(idle_o), 64'd1);
      repeat (2) @(negedge clk_i);
      reset_i = 1'b1;
      repeat (5) @(negedge clk_i);
      exp_dat = '1;
      send_bits("fresh", 11'b0, 2, 11, exp_dat);

      // No resync: samples every baud_i+1 clocks even across an rxd edge
      do_reset();
      eedd_i = 1'b0;
      eedc_i = 1'b0;
      rxd_i  = 1'b0;
      wait_sample("s0", s0);
      repeat (10) @(negedge clk_i);
      rxd_i = 1'b1;
      wait_sample("s1", s1);
      wait_sample("s2", s2);
      check_eq("gap01", 64'(s1 - s0), 64'd50);
      check_eq("gap12", 64'(s2 - s1), 64'd50);
      eedd_i = 1'b1;
      eedc_i = 1'b1;

      // bits_i=0: start edge leaves the block idle
      do_reset();
      bits_i = 6'd0;
      rxd_i  = 1'b0;
      repeat (40) @(negedge clk_i);
      check_eq("b0_idle", 64'(idle_o), 64'd1);
      check_eq("b0_dat", dat_o, 64'hFFFF_FFFF_FFFF_FFFF);
      bits_i = 6'd11;

      // baud_i=0: a sample every clock
      baud_i = 32'd0;
      do_reset();
      check_eq("baud0_a", 64'(sample_to), 64'd1);
      @(negedge clk_i);
      check_eq("baud0_b", 64'(sample_to), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sia_receiver.md
SIA_RECEIVER -- requirements
Module: sia_receiver

Interface
REQ-001 SHALL have parameter SHIFT_REG_WIDTH, default 64, giving the width of the receive shift register and dat_o.
REQ-002 SHALL have parameter BAUD_RATE_WIDTH, default 32, giving the width of baud_i and the baud counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port bits_i, input, 6 bits: bits per frame, start and stop bits included (11 for 8O1).
REQ-006 SHALL have port baud_i, input, BAUD_RATE_WIDTH bits: clocks per bit minus 1 (49 gives 1 Mbps at 50 MHz).
REQ-007 SHALL have port eedd_i, input, 1 bit: enables resynchronization on any rxd_i edge.
REQ-008 SHALL have port eedc_i, input, 1 bit: enables resynchronization on rising edges of rxc_i.
REQ-009 SHALL have port rxd_i, input, 1 bit: serial data, idle high.
REQ-010 SHALL have port rxc_i, input, 1 bit: optional receive clock.
REQ-011 SHALL have port dat_o, output, SHIFT_REG_WIDTH bits: receive shift register contents.
REQ-012 SHALL have port idle_o, output, 1 bit: high when no frame is in progress.
REQ-013 SHALL have port sample_to, output, 1 bit: one-clock strobe on each sample instant.

Function
REQ-014 SHALL pass rxd_i and rxc_i through 2-flop synchronizers; all edge detection and sampling SHALL use the synchronized values.
REQ-015 SHALL hold a down-counting baud counter; on a qualifying edge it SHALL load floor(baud_i/2), so sampling falls at mid-bit.
REQ-016 A qualifying edge SHALL be: any rxd change with eedd_i=1, or an rxc 0->1 transition with eedc_i=1.
REQ-017 When no qualifying edge occurs and the counter is 0, it SHALL assert sample_to for one clock and reload baud_i; otherwise it SHALL decrement.
REQ-018 A qualifying edge SHALL take priority over reload or decrement in the same clock.
REQ-019 Holding a bit counter; idle_o SHALL equal (bit counter == 0).
REQ-020 While idle, a synchronized rxd 1->0 transition SHALL start a frame: bit counter loads bits_i and the baud counter loads floor(baud_i/2), regardless of eedd_i.
REQ-021 Each sample_to while not idle SHALL shift dat_o right by one, with synchronized rxd entering the MSB, and SHALL decrement the bit counter.
REQ-022 While idle, dat_o SHALL hold its value; sample_to may still pulse.
REQ-023 After exactly bits_i samples, idle_o SHALL return to 1; a new frame SHALL require a fresh falling edge.
REQ-024 With bits_i=0, a start edge SHALL leave the block idle.
REQ-025 Counter arithmetic SHALL be unsigned modulo width; baud_i=0 SHALL give a sample every clock.

Reset
REQ-026 While reset_i=0: dat_o=all ones; idle_o=1; sample_to=0; bit and baud counters=0; synchronizer flops=1 for rxd and 0 for rxc.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, without waiting for a clock edge.
REQ-028 After reset deasserts, the first falling rxd edge SHALL start a frame.

Verification
REQ-029 Reset -> idle_o=1, dat_o=64'hFFFF_FFFF_FFFF_FFFF.
REQ-030 Setup: bits_i=11, baud_i=49, eedd_i=eedc_i=1, 20 ns clock. Drive rxd 0,1,0,1,0,0,0,0,1,0,1 at 1000 ns per bit. After each bit period, the top k bits of dat_o equal the bits received so far, with the newest in the MSB; after the 11th bit idle_o=1.
REQ-031 Drive a 12th bit after the frame with rxd held high -> dat_o unchanged and idle_o=1.
REQ-032 Setup: reset, then rxd=0 held low, with 11 rxc pulses of 500 ns high and 500 ns low. After pulse n, dat_o={n zeros, ones}; idle_o=0 for n<=10 and idle_o=1 at n=11.
REQ-033 Assert reset mid-frame -> immediately dat_o=all ones and idle_o=1; the next falling edge starts a fresh frame.
REQ-034 Run with eedd_i=0 and eedc_i=0 -> samples occur every baud_i+1 clocks after the start edge; check sample_to spacing of 50 clocks.
